audio_word_serializer: RTL

// - Upstream feeder of the playback FSM. Fetches 32-bit audio words from the sample ROM and

---
 rtl/audio_word_serializer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/audio_word_serializer.sv
// audio_word_serializer
//   Fetches 32-bit audio words from the sample ROM and shifts each one out
//   MSB-first, one bit every BIT_PERIOD clocks. While the current word is
//   being shifted out, the next word is prefetched, so the stream has no gap
//   at word boundaries. The bit-period, bit-index and word counters are
//   exported so that the playback FSM can time its transitions.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle request to begin playback (sampled in IDLE only)
//   stop                synchronous abort back to IDLE
//   mem_rd, mem_addr    ROM read strobe/address; data is valid the cycle after mem_rd
//   mem_data            ROM read data
//   serial_out          current audio bit
//   big_count           clock index within the current bit
//   thirty_two_count    bit index within the current word
//   packets             index of the word currently being shifted
//   word_done, done     last clock of every word / of the final word
//   busy                high in every state except IDLE
module audio_word_serializer #(
  parameter int BIT_PERIOD  = 400,
  parameter int WORD_W      = 32,
  parameter int NUM_PACKETS = 937,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  output logic              serial_out,
  output logic [8:0]        big_count,
  output logic [4:0]        thirty_two_count,
  output logic [9:0]        packets,
  output logic              word_done,
  output logic              done,
  output logic              busy
);

  localparam logic [8:0] BIG_LAST = 9'(BIT_PERIOD - 1);
  localparam logic [4:0] BIT_LAST = 5'(WORD_W - 1);
  localparam logic [9:0] PKT_LAST = 10'(NUM_PACKETS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT
  } state_t;

  state_t              state_q,  state_d;
  logic [8:0]          big_q,    big_d;
  logic [4:0]          bit_q,    bit_d;
  logic [9:0]          pkt_q,    pkt_d;
  logic [WORD_W-1:0]   shreg_q,  shreg_d;
  logic [WORD_W-1:0]   nword_q,  nword_d;
  logic                rd_q,     rd_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic                serial_q, serial_d;
  logic                wd_q,     wd_d;
  logic                done_q,   done_d;
  logic                busy_q,   busy_d;
  logic                rd_pend_q;
  logic                prefetch;

  always_comb begin
    state_d  = state_q;
    big_d    = big_q;
    bit_d    = bit_q;
    pkt_d    = pkt_q;
    shreg_d  = shreg_q;
    nword_d  = nword_q;
    prefetch = 1'b0;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    serial_d = 1'b0;
    wd_d     = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b0;

    // Prefetched word arrives the cycle after its read strobe.
    if (rd_pend_q && state_q == S_SHIFT) begin
      nword_d = mem_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        shreg_d = mem_data;
        big_d   = '0;
        bit_d   = '0;
        pkt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (big_q == BIG_LAST) begin
          big_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (pkt_q == PKT_LAST) begin
              state_d = S_IDLE;
              pkt_d   = '0;
              shreg_d = '0;
            end else begin
              pkt_d   = pkt_q + 10'd1;
              shreg_d = nword_q;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
          end
        end else begin
          big_d = big_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      big_d   = '0;
      bit_d   = '0;
      pkt_d   = '0;
      shreg_d = '0;
    end

    // Outputs are registered: derive them from the next-state values so that
    // each output is aligned with the state/counters it describes.
    prefetch = (state_d == S_SHIFT) && (big_d == '0) && (bit_d == '0) &&
               (pkt_d < PKT_LAST);
    rd_d     = (state_d == S_FETCH) || prefetch;
    if (state_d == S_FETCH) begin
      addr_d = '0;
    end else if (prefetch) begin
      addr_d = ADDR_W'(pkt_d) + ADDR_W'(1);
    end
    wd_d     = (state_d == S_SHIFT) && (big_d == BIG_LAST) && (bit_d == BIT_LAST);
    done_d   = wd_d && (pkt_d == PKT_LAST);
    serial_d = (state_d == S_SHIFT) ? shreg_d[WORD_W-1] : 1'b0;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      big_q     <= '0;
      bit_q     <= '0;
      pkt_q     <= '0;
      shreg_q   <= '0;
      nword_q   <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      serial_q  <= 1'b0;
      wd_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      big_q     <= big_d;
      bit_q     <= bit_d;
      pkt_q     <= pkt_d;
      shreg_q   <= shreg_d;
      nword_q   <= nword_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      serial_q  <= serial_d;
      wd_q      <= wd_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rd_pend_q <= rd_q;
    end
  end

  assign mem_rd           = rd_q;
  assign mem_addr         = addr_q;
  assign serial_out       = serial_q;
  assign big_count        = big_q;
  assign thirty_two_count = bit_q;
  assign packets          = pkt_q;
  assign word_done        = wd_q;
  assign done             = done_q;
  assign busy             = busy_q;

endmodule
